// File: rtl/div_unit_pkg.sv
// Shared types and defaults for the iterative restoring divider.
// Imported by the handshake interface, the step datapath and the FSM top.
package div_unit_pkg;

  localparam int DIV_DW    = 32;
  localparam int DIV_CNTW  = 6;
  localparam int DIV_RES_W = 2 * DIV_DW;

  typedef enum logic [1:0] {
    DivIdle  = 2'd0,
    DivBusy  = 2'd1,
    DivDZero = 2'd2,
    DivDone  = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// EX-stage divide handshake: EX is the master, the divider is the slave.
// div_res carries {remainder (HI), quotient (LO)} and is qualified by div_ready.
interface div_if
  import div_unit_pkg::*;
#(
  parameter int DW = DIV_DW
);

  logic            div_start;
  logic            div_signed;
  logic [DW-1:0]   opr1;
  logic [DW-1:0]   opr2;
  logic            div_cancel;
  logic            div_hold;
  logic            div_ready;
  logic [2*DW-1:0] div_res;

  modport master (
    output div_start, div_signed, opr1, opr2, div_cancel, div_hold,
    input  div_ready, div_res
  );

  modport slave (
    input  div_start, div_signed, opr1, opr2, div_cancel, div_hold,
    output div_ready, div_res
  );

endinterface

// File: rtl/div_unit_step.sv
// One radix-2 restoring step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and keep the difference if it fits.
module div_step
  import div_unit_pkg::*;
#(
  parameter int DW = DIV_DW
) (
  input  logic [DW-1:0] p,
  input  logic [DW-1:0] q,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] p_next,
  output logic [DW-1:0] q_next
);

  logic [DW:0] shifted;
  logic [DW:0] trial;

  // p < d holds between steps, so trial[DW] is a reliable borrow flag.
  assign shifted = {p, q[DW-1]};
  assign trial   = shifted - {1'b0, d};

  always_comb begin
    if (trial[DW]) begin
      p_next = shifted[DW-1:0];
      q_next = {q[DW-2:0], 1'b0};
    end else begin
      p_next = trial[DW-1:0];
      q_next = {q[DW-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative DIV/DIVU unit beside the EX stage; one quotient bit per cycle,
// result held in div_res for the HI/LO write-back until the next operation.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   DivIdle  | waiting for div_start; operands latched on acceptance
//   DivBusy  | DW restoring iterations, result written on the last one
//   DivDZero | divisor was zero; load {dividend, all ones}
//   DivDone  | div_ready high; held there while div_hold is set
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DW   = DIV_DW,
  parameter int CNTW = DIV_CNTW
) (
  input  logic clk,
  input  logic rst,
  div_if.slave dif
);

  localparam logic [CNTW-1:0] LAST_ITER = CNTW'(DW - 1);

  div_state_e      state;
  logic [CNTW-1:0] cnt;
  logic [DW-1:0]   p_q;
  logic [DW-1:0]   q_q;
  logic [DW-1:0]   d_q;
  logic            qsign;
  logic            rsign;
  logic            ready_q;
  logic [2*DW-1:0] res_q;

  logic            neg1;
  logic            neg2;
  logic [DW-1:0]   abs1;
  logic [DW-1:0]   abs2;
  logic [DW-1:0]   p_nxt;
  logic [DW-1:0]   q_nxt;
  logic [DW-1:0]   rem_fix;
  logic [DW-1:0]   quo_fix;

  // Magnitudes for DIV; the most negative value maps onto itself as unsigned.
  assign neg1 = dif.div_signed & dif.opr1[DW-1];
  assign neg2 = dif.div_signed & dif.opr2[DW-1];
  assign abs1 = neg1 ? -dif.opr1 : dif.opr1;
  assign abs2 = neg2 ? -dif.opr2 : dif.opr2;

  div_step #(.DW(DW)) u_step (
    .p      (p_q),
    .q      (q_q),
    .d      (d_q),
    .p_next (p_nxt),
    .q_next (q_nxt)
  );

  assign rem_fix = rsign ? -p_nxt : p_nxt;
  assign quo_fix = qsign ? -q_nxt : q_nxt;

  assign dif.div_ready = ready_q;
  assign dif.div_res   = res_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= DivIdle;
      cnt     <= '0;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      qsign   <= 1'b0;
      rsign   <= 1'b0;
      ready_q <= 1'b0;
      res_q   <= '0;
    end else if (dif.div_cancel) begin
      state   <= DivIdle;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        DivIdle: begin
          ready_q <= 1'b0;
          cnt     <= '0;
          if (dif.div_start) begin
            p_q   <= '0;
            d_q   <= abs2;
            qsign <= neg1 ^ neg2;
            rsign <= neg1;
            if (dif.opr2 == '0) begin
              q_q   <= dif.opr1;
              state <= DivDZero;
            end else begin
              q_q   <= abs1;
              state <= DivBusy;
            end
          end
        end
        DivBusy: begin
          p_q <= p_nxt;
          q_q <= q_nxt;
          if (cnt == LAST_ITER) begin
            cnt     <= '0;
            res_q   <= {rem_fix, quo_fix};
            ready_q <= 1'b1;
            state   <= DivDone;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DivDZero: begin
          res_q   <= {q_q, {DW{1'b1}}};
          ready_q <= 1'b1;
          state   <= DivDone;
        end
        DivDone: begin
          if (!dif.div_hold) begin
            ready_q <= 1'b0;
            state   <= DivIdle;
          end
        end
        default: begin
          ready_q <= 1'b0;
          state   <= DivIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: expected results come from a longint
// reference model, are queued when a request is driven and popped on div_ready.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div_if #(.DW(32)) dif ();

  div_unit #(.DW(32), .CNTW(6)) dut (
    .clk (clk),
    .rst (rst),
    .dif (dif)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint la, lb, lq, lr;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
    end else begin
      la = longint'({32'd0, a});
      lb = longint'({32'd0, b});
    end
    lq = la / lb;
    lr = la % lb;
    return {lr[31:0], lq[31:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    dif.div_signed = sgn;
    dif.opr1       = a;
    dif.opr2       = b;
    dif.div_start  = 1'b1;
  endtask

  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    exp_q.push_back(ref_div(sgn, a, b));
    drive(sgn, a, b);
  endtask

  // Holds div_start until div_ready, then checks latency, result and the drop.
  task automatic wait_result(input string tag, input int exp_lat, output logic [63:0] exp_res);
    int          cyc;
    logic [63:0] got_ready;
    cyc       = 0;
    got_ready = '0;
    exp_res   = '0;
    while (got_ready == '0 && cyc < 200) begin
      tick();
      cyc++;
      got_ready = {63'd0, dif.div_ready};
    end
    dif.div_start = 1'b0;
    if (got_ready == '0) begin
      check_eq({tag, "_timeout"}, got_ready, 64'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    check_eq({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue"}, 64'd0, 64'd1);
      return;
    end
    exp_res = exp_q.pop_front();
    check_eq({tag, "_res"}, dif.div_res, exp_res);
    if (!dif.div_hold) begin
      tick();
      check_eq({tag, "_drop"}, {63'd0, dif.div_ready}, 64'd0);
    end
  endtask

  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    issue(sgn, a, b);
    wait_result(tag, (b == 32'd0) ? 2 : 33, e);
  endtask

  initial begin
    logic [63:0] e;
    int          highs;
    logic [31:0] ra, rb;
    logic        rs;

    rst            = 1'b1;
    dif.div_start  = 1'b0;
    dif.div_signed = 1'b0;
    dif.opr1       = '0;
    dif.opr2       = '0;
    dif.div_cancel = 1'b0;
    dif.div_hold   = 1'b0;
    repeat (3) tick();
    check_eq("rst_ready", {63'd0, dif.div_ready}, 64'd0);
    check_eq("rst_res", dif.div_res, 64'd0);
    rst = 1'b0;
    tick();

    run_op("divu_100_7", 1'b0, 32'd100, 32'd7);
    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
    run_op("divu_5_0", 1'b0, 32'd5, 32'd0);
    run_op("div_m3_0", 1'b1, 32'hFFFF_FFFD, 32'd0);

    // Cancel mid-BUSY, then restart two cycles later.
    drive(1'b0, 32'd9, 32'd3);
    highs = 0;
    repeat (10) begin
      tick();
      if (dif.div_ready) highs++;
    end
    dif.div_cancel = 1'b1;
    dif.div_start  = 1'b0;
    tick();
    dif.div_cancel = 1'b0;
    if (dif.div_ready) highs++;
    tick();
    if (dif.div_ready) highs++;
    check_eq("cancel_busy_ready", 64'(highs), 64'd0);
    run_op("restart_9_3", 1'b0, 32'd9, 32'd3);

    // Cancel together with start in IDLE must not launch anything.
    drive(1'b0, 32'd40, 32'd5);
    dif.div_cancel = 1'b1;
    tick();
    dif.div_start  = 1'b0;
    dif.div_cancel = 1'b0;
    highs = 0;
    repeat (40) begin
      tick();
      if (dif.div_ready) highs++;
    end
    check_eq("cancel_idle_ready", 64'(highs), 64'd0);

    // Hold in DONE keeps the result presented.
    dif.div_hold = 1'b1;
    issue(1'b1, 32'hFFFF_FC18, 32'd9);
    wait_result("hold", 33, e);
    repeat (3) begin
      tick();
      check_eq("hold_ready", {63'd0, dif.div_ready}, 64'd1);
      check_eq("hold_res", dif.div_res, e);
    end
    dif.div_hold = 1'b0;
    tick();
    check_eq("hold_release", {63'd0, dif.div_ready}, 64'd0);

    // Reset mid-BUSY discards the operation and clears the result.
    drive(1'b0, 32'd50, 32'd7);
    repeat (10) tick();
    rst           = 1'b1;
    dif.div_start = 1'b0;
    tick();
    check_eq("rst_busy_ready", {63'd0, dif.div_ready}, 64'd0);
    check_eq("rst_busy_res", dif.div_res, 64'd0);
    rst = 1'b0;
    tick();
    run_op("after_rst", 1'b0, 32'd50, 32'd7);

    for (int i = 0; i < 8; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = (i == 5) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      run_op("rand", rs, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider; the responder side of the EX-stage divide handshake (div_start / div_signed / div_ready).
- EX holds div_start high while div_ready is low. This block runs the division and raises div_ready with {remainder, quotient} for the HI/LO write-back.
- Sits beside the EX stage. Cancelled by pipeline flush.

Parameters:
- DW, 32, operand width; result width is 2*DW.
- CNTW, 6, iteration counter width; must satisfy 2^CNTW > DW.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- div_start  in  1  request from EX; sampled only in IDLE.
- div_signed  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with div_start.
- opr1  in  DW  dividend; sampled with div_start.
- opr2  in  DW  divisor; sampled with div_start.
- div_cancel  in  1  pipeline flush; aborts any operation.
- div_hold  in  1  EX stage stalled by a later stage; keeps the result presented.
- div_ready  out  1  result valid.
- div_res  out  2*DW  [2DW-1:DW] = remainder (HI), [DW-1:0] = quotient (LO).

Behaviour:
- Reset: clk and rst only; rst is synchronous, active-high. Next state IDLE, div_ready = 0, div_res = 0, counter = 0.
- States:
  - IDLE: if div_start && !div_cancel, latch the operands and go to BUSY, or to DZERO when opr2 == 0.
  - BUSY: perform DW iterations, then go to DONE.
  - DZERO: load the divide-by-zero result, then go to DONE.
  - DONE: div_ready = 1.
- Operand latch (in IDLE, when start is accepted):
  - Signed: store |opr1| and |opr2| as unsigned DW-bit values, plus qsign = opr1[DW-1] ^ opr2[DW-1] and rsign = opr1[DW-1].
  - Unsigned: store opr1 and opr2 raw, with qsign = rsign = 0.
  - |0x80000000| = 0x80000000 as an unsigned value.
- Iteration (BUSY): DW+1-bit partial remainder P, quotient shift register Q, one bit per cycle.
  - T = {P[DW-1:0], Q[DW-1]} - {0, D}.
  - If T is non-negative: P = T, shift 1 into Q. Otherwise keep the shifted P and shift 0 into Q.
  - Counter counts 0..DW-1. Leave BUSY when the counter reaches DW-1.
- Finish (BUSY->DONE edge): div_res = {rsign ? -P : P, qsign ? -Q : Q}, truncated to DW bits each.
  - Overflow case 0x80000000 / -1 gives quotient 0x80000000, remainder 0.
- Divide by zero: result is {opr1 as sampled, all ones}, regardless of div_signed. div_ready rises 2 cycles after acceptance.
- Latency: start accepted at edge T; div_ready = 1 in the cycle after edge T+DW+1, i.e. 33 cycles of stall for DW = 32.
- DONE:
  - div_ready = 1 and div_res stable.
  - Stays in DONE while div_hold = 1.
  - Goes to IDLE when div_hold = 0; div_ready drops the next cycle.
  - div_start is ignored while in DONE.
- div_res holds its last value in IDLE. Only div_ready qualifies it.
- div_cancel = 1 in any state: next state IDLE, div_ready = 0 next cycle, counter cleared, no result written.
  - Cancel has priority over div_start, div_hold and completion in the same cycle.
- rst has priority over everything, including mid-BUSY. The result is discarded.
- div_start deasserting mid-BUSY without cancel: the operation completes anyway. EX must use div_cancel to abort.

Decomposition:
- Shared defines file: state encodings DivIdle, DivBusy, DivDZero, DivDone (2-bit `DivState`); `DivResBus` (63:0) range macro.
- One natural combinational sub-module, div_step: one restoring subtract/shift step, with inputs P, Q, D and outputs P', Q'. This keeps the FSM file small and lets a radix-4 variant be swapped in later.
- Sign fix-up stays inline.

Test Plan:
1. DIVU 100 / 7: start at cycle 0 -> div_ready first high at cycle 33, div_res = {0x00000002, 0x0000000E}; no earlier ready.
2. DIV -7 / 2 (0xFFFFFFF9, 0x00000002) -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 7 / -2 -> LO = 0xFFFFFFFD, HI = 0x00000001.
3. DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0x00000000; DIVU 0xFFFFFFFF / 1 -> LO = 0xFFFFFFFF, HI = 0.
4. DIVU 5 / 0 -> div_ready at cycle 2, div_res = {0x00000005, 0xFFFFFFFF}.
5. DIVU 9 / 3 with div_cancel pulsed at cycle 10 -> div_ready never rises. A new start at cycle 12 -> ready at cycle 45 with {0, 3}. Cancel asserted together with start in IDLE -> stays IDLE.
6. div_hold = 1 for 3 cycles in DONE -> div_ready and div_res constant for 4 cycles, then ready = 0. rst asserted mid-BUSY -> div_ready = 0 and div_res = 0 the next cycle.
